// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: valid/ready bundle between the round controller and the MixColumns engine
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;
    modport master (output in_valid, state_in, out_ready, input in_ready, out_valid, state_out, busy);
    modport slave  (input in_valid, state_in, out_ready, output in_ready, out_valid, state_out, busy);
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, LANES output bytes per clock from a captured source state
module mix_columns_seq #(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst,
    mix_columns_seq_if.slave   mc
);
    localparam int NSTEP = 16 / LANES;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("mix_columns_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [127:0]  src_q, src_d, acc_q, acc_d, out_q, out_d;
    logic [3:0]    lane_k [LANES];
    logic [7:0]    lane_o [LANES];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] byte_at(input logic [127:0] s, input logic [3:0] k);
        return s[8*(15-int'(k)) +: 8];
    endfunction

    // Row rotation within a column wraps naturally in the 2-bit row field of k
    function automatic logic [7:0] mix_byte(input logic [127:0] s, input logic [3:0] k);
        logic [7:0] b0, b1, b2, b3;
        b0 = byte_at(s, k);
        b1 = byte_at(s, {k[3:2], k[1:0] + 2'd1});
        b2 = byte_at(s, {k[3:2], k[1:0] + 2'd2});
        b3 = byte_at(s, {k[3:2], k[1:0] + 2'd3});
        return xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    endfunction

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_k[j] = 4'(int'(step_q) * LANES + j);
        assign lane_o[j] = mix_byte(src_q, lane_k[j]);
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        src_d   = src_q;
        acc_d   = acc_q;
        out_d   = out_q;
        if (state_q == IDLE && mc.in_valid) begin
            state_d = RUN;
            step_d  = '0;
            src_d   = mc.state_in;
        end
        if (state_q == RUN) begin
            for (int j = 0; j < LANES; j++) acc_d[8*(15-int'(lane_k[j])) +: 8] = lane_o[j];
            step_d = step_q + 1'b1;
            if (step_q == SW'(NSTEP - 1)) begin
                state_d = DONE;
                out_d   = acc_d;
            end
        end
        if (state_q == DONE && mc.out_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            src_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            src_q   <= src_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign mc.in_ready  = (state_q == IDLE);
    assign mc.out_valid = (state_q == DONE);
    assign mc.busy      = (state_q != IDLE);
    assign mc.state_out = out_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed and random checks of three engines (LANES 1, 2, 4) against a scoreboard
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   iv = '0;
    logic [2:0]   ordy = '0;
    logic [127:0] si [3];
    wire  [2:0]   ir, ov, bz;
    wire  [127:0] so [3];
    logic [127:0] sb [3][$];
    int           acc [3];
    int           res [3];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq_if ifc ();
        assign ifc.in_valid  = iv[g];
        assign ifc.state_in  = si[g];
        assign ifc.out_ready = ordy[g];
        assign ir[g] = ifc.in_ready;
        assign ov[g] = ifc.out_valid;
        assign bz[g] = ifc.busy;
        assign so[g] = ifc.state_out;
        mix_columns_seq #(.LANES(1 << g)) dut (.clk(clk), .rst(rst), .mc(ifc.slave));
    end

    function automatic logic [7:0] m2(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    function automatic logic [7:0] m3(input logic [7:0] x);
        return m2(x) ^ x;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            {a0, a1, a2, a3} = col;
            o[127-32*c -: 32] = {m2(a0) ^ m3(a1) ^ a2 ^ a3,
                                 a0 ^ m2(a1) ^ m3(a2) ^ a3,
                                 a0 ^ a1 ^ m2(a2) ^ m3(a3),
                                 m3(a0) ^ a1 ^ a2 ^ m2(a3)};
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes seen mid-cycle fire on the coming edge, so score them here
    task automatic cyc();
        logic [127:0] e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst && iv[i] && ir[i]) begin
                sb[i].push_back(mix(si[i]));
                acc[i]++;
            end
            if (!rst && ov[i] && ordy[i]) begin
                res[i]++;
                chk($sformatf("sb_pending%0d", i), 128'(sb[i].size() > 0), 128'(1));
                if (sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    chk($sformatf("sb_data%0d", i), so[i], e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int i, input int max, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!ov[i] && n < max);
    endtask

    task automatic send(input int i, input logic [127:0] s);
        iv[i] = 1'b1;
        si[i] = s;
        cyc();
        iv[i] = 1'b0;
    endtask

    localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1X = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V2X = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] VA  = {4{32'hd4d4d4d5}};
    localparam logic [127:0] VAX = {4{32'hd5d5d7d6}};
    localparam logic [127:0] VB  = {4{32'h2d26314c}};
    localparam logic [127:0] VBX = {4{32'h4d7ebdf8}};

    initial begin
        int n;
        int guard;
        logic [127:0] hold;
        for (int i = 0; i < 3; i++) begin
            si[i]  = '0;
            acc[i] = 0;
            res[i] = 0;
        end
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 128'(ir[i]), 128'(1));
            chk($sformatf("rst_out_valid%0d", i), 128'(ov[i]), 128'(0));
            chk($sformatf("rst_busy%0d", i), 128'(bz[i]), 128'(0));
            chk($sformatf("rst_state_out%0d", i), so[i], '0);
        end

        send(0, V1);
        chk("v1_busy", 128'(bz[0]), 128'(1));
        wait_ov(0, 40, n);
        chk("v1_latency", 128'(n), 128'(16));
        chk("v1_data", so[0], V1X);
        hold = so[0];
        for (int k = 0; k < 10; k++) begin
            iv[0] = k[0];
            si[0] = VB;
            cyc();
            chk("bp_out_valid", 128'(ov[0]), 128'(1));
            chk("bp_state_out", so[0], hold);
            chk("bp_in_ready", 128'(ir[0]), 128'(0));
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        cyc();
        ordy[0] = 1'b0;
        chk("bp_release_in_ready", 128'(ir[0]), 128'(1));
        chk("bp_release_out_valid", 128'(ov[0]), 128'(0));
        chk("bp_release_busy", 128'(bz[0]), 128'(0));
        chk("bp_hold_after_done", so[0], V1X);

        send(2, V2);
        wait_ov(2, 20, n);
        chk("v2_latency", 128'(n), 128'(4));
        chk("v2_data", so[2], V2X);
        ordy[2] = 1'b1;
        cyc();
        ordy[2] = 1'b0;
        chk("v2_release", 128'(ir[2]), 128'(1));

        iv[0]   = 1'b1;
        si[0]   = VA;
        ordy[0] = 1'b1;
        cyc();
        si[0] = VB;
        wait_ov(0, 40, n);
        chk("b2b_first", so[0], VAX);
        chk("b2b_done_in_ready", 128'(ir[0]), 128'(0));
        cyc();
        chk("b2b_idle_in_ready", 128'(ir[0]), 128'(1));
        chk("b2b_idle_out_valid", 128'(ov[0]), 128'(0));
        cyc();
        iv[0] = 1'b0;
        chk("b2b_second_accept", 128'(bz[0]), 128'(1));
        wait_ov(0, 40, n);
        chk("b2b_second_latency", 128'(n), 128'(16));
        chk("b2b_second", so[0], VBX);
        cyc();
        ordy[0] = 1'b0;

        send(0, V1);
        for (int k = 0; k < 5; k++) cyc();
        chk("mid_run_busy", 128'(bz[0]), 128'(1));
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(ov[0]), 128'(0));
        chk("arst_busy", 128'(bz[0]), 128'(0));
        chk("arst_state_out", so[0], '0);
        for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            acc[i] = 0;
            res[i] = 0;
        end
        cyc();
        rst = 1'b0;
        chk("arst_in_ready", 128'(ir[0]), 128'(1));
        send(0, V1);
        wait_ov(0, 40, n);
        chk("post_rst_latency", 128'(n), 128'(16));
        chk("post_rst_data", so[0], V1X);
        ordy[0] = 1'b1;
        cyc();
        ordy[0] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            acc[i] = 0;
            res[i] = 0;
        end
        guard = 0;
        while (acc[0] + acc[1] + acc[2] < 1000 && guard < 60000) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = $urandom_range(0, 3) != 0;
                si[i]   = {$urandom, $urandom, $urandom, $urandom};
                ordy[i] = $urandom_range(0, 2) != 0;
            end
            cyc();
            guard++;
        end
        chk("rand_accepts", 128'(acc[0] + acc[1] + acc[2] >= 1000), 128'(1));
        iv   = '0;
        ordy = '1;
        guard = 0;
        while ((bz != 3'b000 || sb[0].size() + sb[1].size() + sb[2].size() != 0) && guard < 100) begin
            cyc();
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rand_count%0d", i), 128'(res[i]), 128'(acc[i]));
            chk($sformatf("rand_drained%0d", i), 128'(sb[i].size()), 128'(0));
            chk($sformatf("rand_active%0d", i), 128'(acc[i] > 0), 128'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
